mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-client burst arbiter sharing one memory port between the I-cache (client 0, read-only)
// and the D-cache (client 1). Grants alternate under contention and bursts run to memory Last.
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 22,
    parameter int BURST_LEN  = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset_n,
    input  logic                  i_C0_Valid,
    input  logic [ADDR_WIDTH-1:0] i_C0_Address,
    input  logic                  i_C1_Valid,
    input  logic                  i_C1_Read_Write_n,
    input  logic [ADDR_WIDTH-1:0] i_C1_Address,
    input  logic [DATA_WIDTH-1:0] i_C1_Data,
    output logic                  o_C0_Valid,
    output logic                  o_C0_Data_Read,
    output logic                  o_C0_Last,
    output logic [DATA_WIDTH-1:0] o_C0_Data,
    output logic                  o_C1_Valid,
    output logic                  o_C1_Data_Read,
    output logic                  o_C1_Last,
    output logic [DATA_WIDTH-1:0] o_C1_Data,
    output logic                  o_MEM_Valid,
    output logic                  o_MEM_Read_Write_n,
    output logic [ADDR_WIDTH-1:0] o_MEM_Address,
    output logic [DATA_WIDTH-1:0] o_MEM_Data,
    input  logic                  i_MEM_Valid,
    input  logic                  i_MEM_Data_Read,
    input  logic                  i_MEM_Last,
    input  logic [DATA_WIDTH-1:0] i_MEM_Data,
    output logic                  o_Burst_Error
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             grant_q, grant_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             burst_err_q, burst_err_d;
    logic             dir_rd_s;
    logic             beat_s;

    // A beat is a read-data strobe or a write-accept strobe, depending on the granted direction.
    assign dir_rd_s      = grant_q ? i_C1_Read_Write_n : 1'b1;
    assign beat_s        = dir_rd_s ? i_MEM_Valid : i_MEM_Data_Read;
    assign o_Burst_Error = burst_err_q;

    // State, grant, priority, beat counter and sticky error registers.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= 1'b0;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            burst_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            burst_err_q <= burst_err_d;
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats in BUSY, close the burst on a qualified Last.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        burst_err_d = burst_err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_C0_Valid || i_C1_Valid) begin
                    if (i_C0_Valid && i_C1_Valid) begin
                        grant_d = prio_q;
                    end else begin
                        grant_d = i_C1_Valid;
                    end
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (beat_s) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                    // Length is judged on the pre-increment count: the last beat must see BURST_LEN-1.
                    if (i_MEM_Last) begin
                        state_d = ST_RELEASE;
                        prio_d  = ~grant_q;
                        if (cnt_q != LAST_IDX) begin
                            burst_err_d = 1'b1;
                        end else begin
                            burst_err_d = burst_err_q;
                        end
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic: in BUSY the granted client is wired straight through to memory; else all quiet.
    always_comb begin
        o_MEM_Valid        = 1'b0;
        o_MEM_Read_Write_n = 1'b0;
        o_MEM_Address      = '0;
        o_MEM_Data         = '0;
        o_C0_Valid         = 1'b0;
        o_C0_Data_Read     = 1'b0;
        o_C0_Last          = 1'b0;
        o_C0_Data          = '0;
        o_C1_Valid         = 1'b0;
        o_C1_Data_Read     = 1'b0;
        o_C1_Last          = 1'b0;
        o_C1_Data          = '0;
        case (state_q)
            ST_BUSY: begin
                o_MEM_Valid = 1'b1;
                if (grant_q) begin
                    o_MEM_Read_Write_n = i_C1_Read_Write_n;
                    o_MEM_Address      = i_C1_Address;
                    o_MEM_Data         = i_C1_Data;
                    o_C1_Valid         = i_MEM_Valid;
                    o_C1_Data_Read     = i_MEM_Data_Read;
                    o_C1_Last          = i_MEM_Last;
                    o_C1_Data          = i_MEM_Data;
                end else begin
                    o_MEM_Read_Write_n = 1'b1;
                    o_MEM_Address      = i_C0_Address;
                    o_MEM_Data         = '0;
                    o_C0_Valid         = i_MEM_Valid;
                    o_C0_Data_Read     = i_MEM_Data_Read;
                    o_C0_Last          = i_MEM_Last;
                    o_C0_Data          = i_MEM_Data;
                end
            end
            default: begin
                o_MEM_Valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a scripted cycle table, hand-written corner sequences,
// and randomized bursts checked against a transaction-level model of grant order and error.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c0v, c1v, c1rw;
    logic [21:0] c0a, c1a;
    logic [31:0] c1d;
    logic        mv, mdr, ml;
    logic [31:0] md;

    logic        o_C0_Valid, o_C0_Data_Read, o_C0_Last;
    logic [31:0] o_C0_Data;
    logic        o_C1_Valid, o_C1_Data_Read, o_C1_Last;
    logic [31:0] o_C1_Data;
    logic        o_MEM_Valid, o_MEM_Read_Write_n;
    logic [21:0] o_MEM_Address;
    logic [31:0] o_MEM_Data;
    logic        o_Burst_Error;

    int n_checks = 0;
    int n_errors = 0;
    int ptr_m    = 0;
    bit err_m    = 1'b0;

    mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(22), .BURST_LEN(4)) dut (
        .i_Clk(clk), .i_Reset_n(rst_n),
        .i_C0_Valid(c0v), .i_C0_Address(c0a),
        .i_C1_Valid(c1v), .i_C1_Read_Write_n(c1rw), .i_C1_Address(c1a), .i_C1_Data(c1d),
        .o_C0_Valid(o_C0_Valid), .o_C0_Data_Read(o_C0_Data_Read), .o_C0_Last(o_C0_Last),
        .o_C0_Data(o_C0_Data),
        .o_C1_Valid(o_C1_Valid), .o_C1_Data_Read(o_C1_Data_Read), .o_C1_Last(o_C1_Last),
        .o_C1_Data(o_C1_Data),
        .o_MEM_Valid(o_MEM_Valid), .o_MEM_Read_Write_n(o_MEM_Read_Write_n),
        .o_MEM_Address(o_MEM_Address), .o_MEM_Data(o_MEM_Data),
        .i_MEM_Valid(mv), .i_MEM_Data_Read(mdr), .i_MEM_Last(ml), .i_MEM_Data(md),
        .o_Burst_Error(o_Burst_Error)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    typedef struct {
        logic c0v, c1v, c1rw; logic [21:0] c1a; logic [31:0] c1d;
        logic mv, mdr, ml; logic [31:0] md;
        logic e_mv, e_rw; logic [21:0] e_ma; logic [31:0] e_md;
        logic e_c0v, e_c0l; logic [31:0] e_c0d;
        logic e_c1v, e_c1dr, e_c1l; logic [31:0] e_c1d;
    } vec_t;

    vec_t vecs[24];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mem_idle();
        mv = 1'b0; mdr = 1'b0; ml = 1'b0; md = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        c0v = 1'b0; c1v = 1'b0; c1rw = 1'b1; c0a = 22'h0; c1a = 22'h0; c1d = 32'h0;
        mv = 1'b1; mdr = 1'b1; ml = 1'b1; md = 32'hFFFF_FFFF;
        tick();
        chk("reset_outputs", {o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data,
                              o_C0_Valid, o_C0_Data_Read, o_C0_Last, o_C0_Data, o_C1_Valid,
                              o_C1_Data_Read, o_C1_Last, o_C1_Data, o_Burst_Error}, 128'h0);
        mem_idle();
        tick();
        rst_n = 1'b1;
        ptr_m = 0;
        err_m = 1'b0;
    endtask

    // One arbitration round: request in IDLE, nbeats memory beats with random stalls, RELEASE.
    task automatic xact(input bit v0, input bit v1, input bit rw1, input int nbeats,
                        input bit drop, input bit hold, output int gobs);
        logic [21:0] a0, a1;
        logic [31:0] d1;
        int win;
        a0 = 22'($urandom) & 22'h3FFFFE;
        a1 = 22'($urandom) & 22'h3FFFFE;
        d1 = $urandom;
        c0v = v0; c1v = v1; c1rw = rw1; c0a = a0; c1a = a1; c1d = d1;
        mem_idle();
        #1 chk("idle_mem_valid", o_MEM_Valid, 1'b0);
        win = (v0 && v1) ? ptr_m : (v1 ? 1 : 0);
        tick();
        gobs = -1;
        for (int k = 0; k < nbeats; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                mem_idle();
                #1 chk("stall_mem_valid", o_MEM_Valid, 1'b1);
                chk("stall_clients", {o_C0_Valid, o_C1_Valid, o_C0_Data_Read, o_C1_Data_Read,
                                      o_C0_Last, o_C1_Last}, 6'h0);
                tick();
            end
            md = $urandom; mv = 1'b1; mdr = 1'b1; ml = (k == nbeats - 1);
            #1;
            chk("busy_mem_valid", o_MEM_Valid, 1'b1);
            chk("busy_mem_addr", o_MEM_Address, (win == 1) ? a1 : a0);
            chk("busy_mem_rw", o_MEM_Read_Write_n, (win == 1) ? rw1 : 1'b1);
            chk("busy_mem_data", o_MEM_Data, (win == 1) ? d1 : 32'h0);
            if (k == 0) gobs = o_C1_Valid ? 1 : (o_C0_Valid ? 0 : -1);
            if (win == 1) begin
                chk("granted_c1", {o_C1_Valid, o_C1_Data_Read, o_C1_Last, o_C1_Data},
                    {1'b1, 1'b1, ml, md});
                chk("quiet_c0", {o_C0_Valid, o_C0_Data_Read, o_C0_Last, o_C0_Data}, 35'h0);
            end else begin
                chk("granted_c0", {o_C0_Valid, o_C0_Data_Read, o_C0_Last, o_C0_Data},
                    {1'b1, 1'b1, ml, md});
                chk("quiet_c1", {o_C1_Valid, o_C1_Data_Read, o_C1_Last, o_C1_Data}, 35'h0);
            end
            tick();
            if (drop && k == 0) begin
                c0v = 1'b0; c1v = 1'b0;
            end
        end
        if (nbeats != 4) err_m = 1'b1;
        ptr_m = 1 - win;
        mem_idle();
        if (!hold) begin
            c0v = 1'b0; c1v = 1'b0;
        end
        #1;
        chk("release_mem_valid", o_MEM_Valid, 1'b0);
        chk("release_err", o_Burst_Error, err_m);
        tick();
    endtask

    initial begin
        int g;
        logic [127:0] act, exp;
        vec_t v;
        vecs[0]  = '{0,0,1,22'h0,32'h0,   0,0,0,32'h0,       0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};
        vecs[1]  = '{1,0,1,22'h0,32'h0,   0,0,0,32'h0,       0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};
        vecs[2]  = '{1,0,1,22'h0,32'h0,   1,0,0,32'hA0A0_0001, 1,1,22'h100,32'h0, 1,0,32'hA0A0_0001, 0,0,0,32'h0};
        vecs[3]  = '{1,0,1,22'h0,32'h0,   0,0,0,32'h0,       1,1,22'h100,32'h0,   0,0,32'h0,       0,0,0,32'h0};
        vecs[4]  = '{1,0,1,22'h0,32'h0,   1,0,0,32'hB0B0_0002, 1,1,22'h100,32'h0, 1,0,32'hB0B0_0002, 0,0,0,32'h0};
        vecs[5]  = '{1,0,1,22'h0,32'h0,   1,0,0,32'hC0C0_0003, 1,1,22'h100,32'h0, 1,0,32'hC0C0_0003, 0,0,0,32'h0};
        vecs[6]  = '{1,0,1,22'h0,32'h0,   1,0,1,32'hD0D0_0004, 1,1,22'h100,32'h0, 1,1,32'hD0D0_0004, 0,0,0,32'h0};
        vecs[7]  = '{0,0,1,22'h0,32'h0,   1,1,1,32'hDEAD,    0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};
        vecs[8]  = '{0,0,1,22'h0,32'h0,   0,0,0,32'h0,       0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};
        vecs[9]  = '{0,1,0,22'h200,32'h11, 0,0,0,32'h0,      0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};
        vecs[10] = '{0,1,0,22'h200,32'h11, 0,1,0,32'h0,      1,0,22'h200,32'h11,  0,0,32'h0,       0,1,0,32'h0};
        vecs[11] = '{0,1,0,22'h200,32'h22, 0,1,0,32'h0,      1,0,22'h200,32'h22,  0,0,32'h0,       0,1,0,32'h0};
        vecs[12] = '{0,1,0,22'h200,32'h33, 0,0,0,32'h0,      1,0,22'h200,32'h33,  0,0,32'h0,       0,0,0,32'h0};
        vecs[13] = '{0,1,0,22'h200,32'h33, 0,1,0,32'h0,      1,0,22'h200,32'h33,  0,0,32'h0,       0,1,0,32'h0};
        vecs[14] = '{0,1,0,22'h200,32'h44, 0,1,1,32'h0,      1,0,22'h200,32'h44,  0,0,32'h0,       0,1,1,32'h0};
        vecs[15] = '{0,1,1,22'h300,32'h0, 0,0,0,32'h0,       0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};
        vecs[16] = '{0,1,1,22'h300,32'h0, 0,0,0,32'h0,       0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};
        vecs[17] = '{0,1,1,22'h300,32'h0, 1,0,0,32'h5,       1,1,22'h300,32'h0,   0,0,32'h0,       1,0,0,32'h5};
        vecs[18] = '{0,1,1,22'h300,32'h0, 0,0,1,32'h0,       1,1,22'h300,32'h0,   0,0,32'h0,       0,0,1,32'h0};
        vecs[19] = '{0,1,1,22'h300,32'h0, 1,0,0,32'h6,       1,1,22'h300,32'h0,   0,0,32'h0,       1,0,0,32'h6};
        vecs[20] = '{0,1,1,22'h300,32'h0, 1,0,0,32'h7,       1,1,22'h300,32'h0,   0,0,32'h0,       1,0,0,32'h7};
        vecs[21] = '{0,1,1,22'h300,32'h0, 1,0,1,32'h8,       1,1,22'h300,32'h0,   0,0,32'h0,       1,0,1,32'h8};
        vecs[22] = '{0,0,1,22'h0,32'h0,   0,0,0,32'h0,       0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};
        vecs[23] = '{0,0,1,22'h0,32'h0,   0,0,0,32'h0,       0,0,22'h0,32'h0,     0,0,32'h0,       0,0,0,32'h0};

        do_reset();

        // Scripted C0 read, C1 write-back then refill, and an unqualified Last mid-burst.
        for (int i = 0; i < 24; i++) begin
            v = vecs[i];
            c0v = v.c0v; c0a = 22'h000100; c1v = v.c1v; c1rw = v.c1rw; c1a = v.c1a; c1d = v.c1d;
            mv = v.mv; mdr = v.mdr; ml = v.ml; md = v.md;
            #1;
            act = {o_MEM_Valid, o_MEM_Read_Write_n, o_MEM_Address, o_MEM_Data,
                   o_C0_Valid, o_C0_Data_Read, o_C0_Last, o_C0_Data,
                   o_C1_Valid, o_C1_Data_Read, o_C1_Last, o_C1_Data};
            exp = {v.e_mv, v.e_rw, v.e_ma, v.e_md, v.e_c0v, 1'b0, v.e_c0l, v.e_c0d,
                   v.e_c1v, v.e_c1dr, v.e_c1l, v.e_c1d};
            chk($sformatf("vec[%0d]", i), act, exp);
            tick();
        end
        chk("table_no_error", o_Burst_Error, 1'b0);

        // Both clients requesting continuously after reset: grants alternate starting with C0.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            xact(1'b1, 1'b1, (i == 1) ? 1'b0 : 1'b1, 4, 1'b0, 1'b1, g);
            chk("alternating_grant", g, i % 2);
        end
        chk("alternating_no_error", o_Burst_Error, 1'b0);

        // Short burst raises the sticky error; a correct burst afterwards leaves it set.
        xact(1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0, g);
        xact(1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b0, g);
        chk("error_sticky", o_Burst_Error, 1'b1);

        // Granted client drops Valid mid-burst; grant and o_MEM_Valid persist until Last.
        xact(1'b0, 1'b1, 1'b1, 4, 1'b1, 1'b0, g);
        chk("drop_grant", g, 1);

        // Reset pulsed during beat 2 of a C1 read.
        do_reset();
        c1v = 1'b1; c1rw = 1'b1; c1a = 22'h000300;
        tick();
        mv = 1'b1; md = 32'h1111;
        tick();
        md = 32'h2222;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_mem_valid", o_MEM_Valid, 1'b0);
        chk("reset_mid_c1", {o_C1_Valid, o_C1_Data}, 33'h0);
        tick();
        rst_n = 1'b1; c1v = 1'b0; mem_idle();
        ptr_m = 0; err_m = 1'b0;
        xact(1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0, g);
        chk("post_reset_grant", g, 0);
        chk("post_reset_no_error", o_Burst_Error, 1'b0);

        // Randomized bursts against the transaction-level model.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            int pat;
            int nb;
            pat = $urandom_range(1, 3);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 4;
            xact(pat[0], pat[1], 1'($urandom), nb, ($urandom_range(0, 7) == 0),
                 1'($urandom), g);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
